// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: OPMODE field encodings and sequencer state constants shared by the MAC sequencer
package dsp48a1_pkg;
  typedef enum logic [1:0] {X_ZERO = 2'd0, X_M = 2'd1, X_P = 2'd2, X_DAB = 2'd3} x_sel_e;
  typedef enum logic [1:0] {Z_ZERO = 2'd0, Z_PCIN = 2'd1, Z_P = 2'd2, Z_C = 2'd3} z_sel_e;
  // Upper nibble zero: post-adder adds, pre-adder bypassed, carry-in select 0
  function automatic logic [7:0] opm(input x_sel_e x, input z_sel_e z);
    return {4'b0000, z, x};
  endfunction
  localparam logic [7:0] OPM_MUL_FIRST = opm(X_M, Z_ZERO);
  localparam logic [7:0] OPM_MAC = opm(X_M, Z_P);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/dsp48a1_mac_sequencer_if.sv
// dsp48a1_mac_sequencer_if: job, operand and result handshakes of the MAC sequencer
interface dsp48a1_mac_sequencer_if #(parameter int LEN_W = 16);
  logic job_valid, job_ready;
  logic [LEN_W-1:0] job_len;
  logic op_valid, op_ready;
  logic [17:0] op_a, op_b;
  logic res_valid, res_ready;
  logic [47:0] res_data;
  modport master(output job_valid, job_len, op_valid, op_a, op_b, res_ready,
                 input job_ready, op_ready, res_valid, res_data);
  modport slave(input job_valid, job_len, op_valid, op_a, op_b, res_ready,
                output job_ready, op_ready, res_valid, res_data);
endinterface

// File: rtl/dsp48a1_valid_pipe.sv
// dsp48a1_valid_pipe: tags issued operand pairs so the M and P registers only clock on real data
module dsp48a1_valid_pipe #(
  parameter int MREG_LAT = 1,
  parameter int PREG_LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic tag,
  output logic cem,
  output logic cep,
  output logic empty
);
  localparam int N = MREG_LAT + PREG_LAT;
  logic [N-1:0] sr;
  always_ff @(posedge clk)
    if (!rstn) sr <= '0;
    else sr <= {sr[N-2:0], tag};
  assign cem = sr[MREG_LAT-1];
  assign cep = sr[N-1];
  assign empty = ~|sr;
endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// dsp48a1_mac_sequencer: streams operand pairs into one DSP48A1 slice and returns sum(A*B)
module dsp48a1_mac_sequencer
  import dsp48a1_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int MREG_LAT = 1,
  parameter int PREG_LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  dsp48a1_mac_sequencer_if.slave bus,
  output logic busy,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0] dsp_opmode,
  output logic dsp_cea,
  output logic dsp_ceb,
  output logic dsp_ceopmode,
  output logic dsp_cem,
  output logic dsp_cep,
  output logic dsp_rst,
  input  logic [47:0] dsp_p
);
  logic [1:0] state;
  logic [LEN_W-1:0] left;
  logic up, first, hs, empty;
  assign hs = bus.op_valid && state == ST_ISSUE;
  assign bus.job_ready = up && state == ST_IDLE;
  assign bus.op_ready = state == ST_ISSUE;
  assign bus.res_valid = state == ST_DONE;
  assign busy = state != ST_IDLE;
  assign dsp_rst = ~up;
  assign dsp_cea = hs;
  assign dsp_ceb = hs;
  assign dsp_ceopmode = hs;
  assign dsp_a = hs ? bus.op_a : '0;
  assign dsp_b = hs ? bus.op_b : '0;
  // First pair of a job overwrites P, later pairs accumulate onto it
  assign dsp_opmode = hs ? (first ? OPM_MUL_FIRST : OPM_MAC) : '0;
  dsp48a1_valid_pipe #(.MREG_LAT(MREG_LAT), .PREG_LAT(PREG_LAT)) u_pipe (
    .clk(clk), .rstn(rstn), .tag(hs), .cem(dsp_cem), .cep(dsp_cep), .empty(empty)
  );
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= ST_IDLE;
      left <= '0;
      up <= 1'b0;
      first <= 1'b0;
      bus.res_data <= '0;
    end else begin
      up <= 1'b1;
      if (bus.job_valid && bus.job_ready) begin
        state <= bus.job_len == '0 ? ST_DONE : ST_ISSUE;
        left <= bus.job_len;
        first <= 1'b1;
        bus.res_data <= '0;
      end
      if (hs) begin
        left <= left - LEN_W'(1);
        first <= 1'b0;
        if (left == LEN_W'(1)) state <= ST_DRAIN;
      end
      if (state == ST_DRAIN && empty) begin
        state <= ST_DONE;
        bus.res_data <= dsp_p;
      end
      if (state == ST_DONE && bus.res_ready) state <= ST_IDLE;
    end
endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb_dsp48a1_mac_sequencer: randomized MAC jobs checked every cycle against a sum-of-products model
module tb_dsp48a1_mac_sequencer;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  dsp48a1_mac_sequencer_if #(.LEN_W(16)) bus();
  logic busy, dsp_cea, dsp_ceb, dsp_ceopmode, dsp_cem, dsp_cep, dsp_rst;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0] dsp_opmode;
  logic [47:0] dsp_p;
  dsp48a1_mac_sequencer dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_ceopmode(dsp_ceopmode),
    .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );
  int checks = 0, failures = 0;
  function automatic void chk(input string n, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", n, act, exp, $time);
    end
  endfunction
  // Idealised slice: OPMODE travels with its operand pair so each P update uses its own mode
  logic [17:0] a_r = '0, b_r = '0;
  logic [7:0] om_a = '0, om_m = '0;
  logic signed [35:0] m_r = '0;
  logic [47:0] p_r = '0;
  always @(posedge clk)
    if (dsp_rst) begin
      a_r <= '0; b_r <= '0; om_a <= '0; om_m <= '0; m_r <= '0; p_r <= '0;
    end else begin
      if (dsp_cea) a_r <= dsp_a;
      if (dsp_ceb) b_r <= dsp_b;
      if (dsp_ceopmode) om_a <= dsp_opmode;
      if (dsp_cem) begin m_r <= $signed(a_r) * $signed(b_r); om_m <= om_a; end
      if (dsp_cep) p_r <= (om_m[3:2] == 2'd2 ? p_r : 48'd0) + (om_m[1:0] == 2'd1 ? 48'(m_r) : 48'd0);
    end
  assign dsp_p = p_r;
  // Behavioural model: job bookkeeping plus sum of products, outputs expected after each edge
  int cyc = 0, left_m = 0, jlen_m = 0, due = 0;
  bit up_m = 0, busy_m = 0, pend = 0, e_jr = 0, e_or = 0, e_rv = 0, h0 = 0, h1 = 0, hs_m;
  logic [47:0] acc = '0;
  logic signed [35:0] pr;
  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      up_m = 0; busy_m = 0; pend = 0; left_m = 0; acc = '0; h0 = 0; h1 = 0;
    end else begin
      hs_m = bus.op_valid && e_or;
      if (bus.job_valid && e_jr) begin
        busy_m = 1; jlen_m = int'(bus.job_len); left_m = jlen_m; acc = '0;
        if (jlen_m == 0) begin pend = 1; due = cyc; end
      end
      if (hs_m) begin
        pr = $signed(bus.op_a) * $signed(bus.op_b);
        acc += 48'(pr);
        left_m--;
        if (left_m == 0) begin pend = 1; due = cyc + 3; end
      end
      if (e_rv && bus.res_ready) begin pend = 0; busy_m = 0; end
      h1 = h0; h0 = hs_m; up_m = 1;
    end
    e_jr = up_m && !busy_m;
    e_or = busy_m && left_m > 0;
    e_rv = pend && cyc >= due;
  end
  int cea_cnt = 0, cem_cnt = 0, cep_cnt = 0;
  bit hs_e;
  always @(negedge clk) if (cyc > 0) begin
    hs_e = bus.op_valid && e_or;
    chk("job_ready", 48'(bus.job_ready), 48'(e_jr));
    chk("op_ready", 48'(bus.op_ready), 48'(e_or));
    chk("busy", 48'(busy), 48'(busy_m));
    chk("res_valid", 48'(bus.res_valid), 48'(e_rv));
    chk("dsp_rst", 48'(dsp_rst), 48'(!up_m));
    chk("dsp_cea", 48'(dsp_cea), 48'(hs_e));
    chk("dsp_ceb", 48'(dsp_ceb), 48'(hs_e));
    chk("dsp_ceopmode", 48'(dsp_ceopmode), 48'(hs_e));
    chk("dsp_cem", 48'(dsp_cem), 48'(h0));
    chk("dsp_cep", 48'(dsp_cep), 48'(h1));
    if (e_rv || !up_m) chk("res_data", bus.res_data, acc);
    if (hs_e) begin
      chk("dsp_a", 48'(dsp_a), 48'(bus.op_a));
      chk("dsp_b", 48'(dsp_b), 48'(bus.op_b));
      chk("dsp_opmode", 48'(dsp_opmode), left_m == jlen_m ? 48'h01 : 48'h09);
    end else if (!up_m) begin
      chk("rst_dsp_a", 48'(dsp_a), 48'd0);
      chk("rst_dsp_b", 48'(dsp_b), 48'd0);
      chk("rst_dsp_opmode", 48'(dsp_opmode), 48'd0);
    end
    if (dsp_cea) cea_cnt++;
    if (dsp_cem) cem_cnt++;
    if (dsp_cep) cep_cnt++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rand_in;
    bus.job_valid = 1'($urandom); bus.job_len = 16'($urandom_range(0, 4));
    bus.op_valid = 1'($urandom); bus.op_a = 18'($urandom); bus.op_b = 18'($urandom);
    bus.res_ready = 1'($urandom);
  endtask
  task automatic clr_in;
    bus.job_valid = 0; bus.job_len = '0; bus.op_valid = 0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 0;
  endtask
  function automatic logic [17:0] rnd18;
    int s;
    s = $urandom_range(0, 3);
    return s == 0 ? 18'h20000 : s == 1 ? 18'h1FFFF : 18'($urandom);
  endfunction
  int last_hs = 0;
  task automatic accept_job(input int len);
    int n = 0;
    bus.job_valid = 1; bus.job_len = 16'(len);
    while (!bus.job_ready && n < 50) begin tick; n++; end
    if (n == 50) begin checks++; failures++; $display("FAIL job_accept: timeout waiting for job_ready"); end
    tick;
    bus.job_valid = 0;
    cea_cnt = 0; cem_cnt = 0; cep_cnt = 0;
  endtask
  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input int gap, input bit noisy);
    int n = 0;
    bus.op_valid = 0;
    repeat (gap) begin
      if (noisy) begin bus.job_valid = 1'($urandom); bus.res_ready = 1'($urandom); end
      tick;
    end
    bus.op_valid = 1; bus.op_a = a; bus.op_b = b;
    while (!bus.op_ready && n < 50) begin tick; n++; end
    if (n == 50) begin checks++; failures++; $display("FAIL op_accept: timeout waiting for op_ready"); end
    tick;
    last_hs = cyc;
    bus.op_valid = 0; bus.job_valid = 0; bus.res_ready = 0;
  endtask
  task automatic get_result(input int hold, input logic [47:0] lit, input bit use_lit, input bit chk_lat, output int waited);
    int n = 0;
    bus.res_ready = 0;
    while (!bus.res_valid && n < 50) begin tick; n++; end
    if (n == 50) begin checks++; failures++; $display("FAIL result: timeout waiting for res_valid"); end
    waited = n;
    if (chk_lat) chk("latency", 48'(cyc - last_hs + 1), 48'd4);
    if (use_lit) chk("res_data_lit", bus.res_data, lit);
    repeat (hold) tick;
    if (use_lit && hold > 0) chk("res_held", bus.res_data, lit);
    bus.res_ready = 1;
    tick;
    bus.res_ready = 0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w, len;
    clr_in();
    rstn = 0;
    repeat (3) begin rand_in(); tick; end
    chk("rst_job_ready", 48'(bus.job_ready), 48'd0);
    chk("rst_dsp_rst", 48'(dsp_rst), 48'd1);
    chk("rst_res_data", bus.res_data, 48'd0);
    clr_in();
    rstn = 1;
    tick;
    chk("release_job_ready", 48'(bus.job_ready), 48'd1);
    accept_job(3);
    send_pair(18'd2, 18'd3, 0, 0); send_pair(18'd4, 18'd5, 0, 0); send_pair(18'd6, 18'd7, 0, 0);
    get_result(0, 48'd68, 1, 1, w);
    accept_job(3);
    send_pair(18'd2, 18'd3, 0, 0); send_pair(18'd4, 18'd5, 2, 0); send_pair(18'd6, 18'd7, 2, 0);
    get_result(0, 48'd68, 1, 1, w);
    chk("bubble_cem_count", 48'(cem_cnt), 48'd3);
    chk("bubble_cep_count", 48'(cep_cnt), 48'd3);
    accept_job(1);
    send_pair(18'h3FFFF, 18'd2, 0, 0);
    get_result(0, 48'hFFFF_FFFF_FFFE, 1, 1, w);
    accept_job(0);
    get_result(5, 48'd0, 1, 0, w);
    chk("len0_wait", 48'(w), 48'd0);
    chk("len0_ce_count", 48'(cea_cnt + cem_cnt + cep_cnt), 48'd0);
    accept_job(4);
    send_pair(18'd5, 18'd6, 0, 0); send_pair(18'd7, 18'd8, 0, 0);
    rstn = 0;
    repeat (3) begin rand_in(); tick; end
    chk("abort_res_valid", 48'(bus.res_valid), 48'd0);
    clr_in();
    rstn = 1;
    tick;
    accept_job(2);
    send_pair(18'd1, 18'd1, 0, 0); send_pair(18'd1, 18'd1, 0, 0);
    get_result(0, 48'd2, 1, 1, w);
    repeat (40) begin
      len = $urandom_range(0, 6);
      accept_job(len);
      for (int i = 0; i < len; i++) send_pair(rnd18(), rnd18(), $urandom_range(0, 2), 1);
      get_result($urandom_range(0, 3), 48'd0, 0, len > 0, w);
    end
    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
